// File: rtl/ip_ram_arbiter.sv
// ip_ram_arbiter: two-master front end for the 16 KB internal RAM.
// m0 (cartridge bus bridge) and m1 (DMA/VDP side) share one RAM request bus.
// Reads are tagged in an in-order FIFO so each returning bus_rdata_en pulse is
// routed back to the master that issued it. After reset the block sits in a
// DRAIN window so responses still in the RAM pipeline are swallowed silently.
//
// Build option: define IP_RAM_ARB_FIXED_PRIORITY_EN for fixed priority (m0
// always wins, m1 may starve). Default build is round-robin.
module ip_ram_arbiter #(
    parameter int MAX_OUTSTANDING = 4,  // tag FIFO depth, power of two, 2..8
    parameter int DRAIN_CYCLES    = 4   // post-reset cycles with no traffic
) (
    input  logic        clk,
    input  logic        reset,

    input  logic [13:0] m0_address,
    input  logic        m0_valid,
    output logic        m0_ready,
    input  logic        m0_write,
    input  logic [7:0]  m0_wdata,
    output logic [7:0]  m0_rdata,
    output logic        m0_rdata_en,

    input  logic [13:0] m1_address,
    input  logic        m1_valid,
    output logic        m1_ready,
    input  logic        m1_write,
    input  logic [7:0]  m1_wdata,
    output logic [7:0]  m1_rdata,
    output logic        m1_rdata_en,

    output logic [13:0] bus_address,
    output logic        bus_valid,
    output logic        bus_write,
    output logic [7:0]  bus_wdata,
    input  logic        bus_ready,
    input  logic [7:0]  bus_rdata,
    input  logic        bus_rdata_en,

    output logic        err_orphan
);

    localparam int PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam int DRN_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

    localparam logic [CNT_W-1:0] FIFO_DEPTH = CNT_W'(MAX_OUTSTANDING);
    localparam logic [DRN_W-1:0] DRAIN_LAST = DRN_W'(DRAIN_CYCLES - 1);

    typedef enum logic {
        ST_DRAIN = 1'b0,
        ST_RUN   = 1'b1
    } state_e;

    // Control state
    state_e           state_q, state_d;
    logic [DRN_W-1:0] drain_cnt_q, drain_cnt_d;

    // Read-tag FIFO: one bit per outstanding read, 0 = m0, 1 = m1.
    // Pointers wrap naturally because the depth is a power of two.
    logic             tag_q [MAX_OUTSTANDING];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;

    // Registered response outputs
    logic             m0_rdata_en_q, m0_rdata_en_d;
    logic             m1_rdata_en_q, m1_rdata_en_d;
    logic [7:0]       m0_rdata_q, m0_rdata_d;
    logic [7:0]       m1_rdata_q, m1_rdata_d;
    logic             err_orphan_q, err_orphan_d;

`ifndef IP_RAM_ARB_FIXED_PRIORITY_EN
    // Round-robin pointer: 0 = m0 preferred, 1 = m1 preferred.
    logic             rr_q, rr_d;
`endif

    // Per-cycle arbitration and FIFO control
    logic run;
    logic fifo_full;
    logic fifo_empty;
    logic elig0, elig1;
    logic grant0, grant1;
    logic accept;
    logic push;
    logic pop;
    logic orphan;
    logic head_tag;

    // Reset is folded in so the combinational request outputs read 0 while
    // reset is held, not only from the first reset edge onward.
    assign run        = (state_q == ST_RUN) && !reset;
    assign fifo_full  = (count_q == FIFO_DEPTH);
    assign fifo_empty = (count_q == '0);
    assign head_tag   = tag_q[rd_ptr_q];

    // Drain window sequencing: count down, then open the bus for good.
    always_comb begin
        // NOTE: every signal gets a default before the case so no path
        // leaves it unassigned, which would otherwise infer a latch.
        state_d     = state_q;
        drain_cnt_d = drain_cnt_q;
        case (state_q)
            ST_DRAIN: begin
                if (drain_cnt_q == '0) begin
                    state_d = ST_RUN;
                end else begin
                    drain_cnt_d = drain_cnt_q - 1'b1;
                end
            end
            ST_RUN:   state_d = ST_RUN;
            default:  state_d = ST_DRAIN;
        endcase
    end

    // Arbitration: pick one eligible master and drive the RAM request bus.
    always_comb begin
        // A read needs a free tag slot; the registered count is used, so a
        // pop in this same cycle does not free a slot for a push.
        elig0 = m0_valid && (m0_write || !fifo_full);
        elig1 = m1_valid && (m1_write || !fifo_full);

`ifdef IP_RAM_ARB_FIXED_PRIORITY_EN
        grant0 = run && elig0;
        grant1 = run && elig1 && !elig0;
`else
        grant0 = run && elig0 && (!elig1 || !rr_q);
        grant1 = run && elig1 && (!elig0 ||  rr_q);
`endif

        bus_valid   = 1'b0;
        bus_write   = 1'b0;
        bus_address = '0;
        bus_wdata   = '0;
        if (grant0) begin
            bus_valid   = 1'b1;
            bus_write   = m0_write;
            bus_address = m0_address;
            bus_wdata   = m0_wdata;
        end else if (grant1) begin
            bus_valid   = 1'b1;
            bus_write   = m1_write;
            bus_address = m1_address;
            bus_wdata   = m1_wdata;
        end

        m0_ready = grant0 && bus_ready;
        m1_ready = grant1 && bus_ready;
        accept   = m0_ready || m1_ready;
        push     = accept && !bus_write;
    end

    // Tag FIFO bookkeeping, response routing and orphan detection.
    always_comb begin
        pop    = run && bus_rdata_en && !fifo_empty;
        orphan = run && bus_rdata_en &&  fifo_empty;

        wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;

        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase

        // Data is forced to zero whenever the strobe for that master is low.
        m0_rdata_en_d = pop && !head_tag;
        m1_rdata_en_d = pop &&  head_tag;
        m0_rdata_d    = m0_rdata_en_d ? bus_rdata : 8'h00;
        m1_rdata_d    = m1_rdata_en_d ? bus_rdata : 8'h00;

        err_orphan_d  = err_orphan_q || orphan;

`ifndef IP_RAM_ARB_FIXED_PRIORITY_EN
        // After an accepted transfer the other master gets preference.
        rr_d = accept ? grant0 : rr_q;
`endif
    end

    // Control and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state is updated with non-blocking assignments so
        // every flop samples the pre-edge values of the others.
        if (reset) begin
            state_q       <= ST_DRAIN;
            drain_cnt_q   <= DRAIN_LAST;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
            m0_rdata_en_q <= 1'b0;
            m1_rdata_en_q <= 1'b0;
            m0_rdata_q    <= 8'h00;
            m1_rdata_q    <= 8'h00;
            err_orphan_q  <= 1'b0;
`ifndef IP_RAM_ARB_FIXED_PRIORITY_EN
            rr_q          <= 1'b0;
`endif
        end else begin
            state_q       <= state_d;
            drain_cnt_q   <= drain_cnt_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            count_q       <= count_d;
            m0_rdata_en_q <= m0_rdata_en_d;
            m1_rdata_en_q <= m1_rdata_en_d;
            m0_rdata_q    <= m0_rdata_d;
            m1_rdata_q    <= m1_rdata_d;
            err_orphan_q  <= err_orphan_d;
`ifndef IP_RAM_ARB_FIXED_PRIORITY_EN
            rr_q          <= rr_d;
`endif
        end
    end

    // Tag storage: written on every accepted read.
    always_ff @(posedge clk) begin
        // NOTE: the tag array is deliberately not reset; an entry is only
        // ever read after it has been written, because count_q gates pops.
        if (push) begin
            tag_q[wr_ptr_q] <= grant1;
        end
    end

    assign m0_rdata    = m0_rdata_q;
    assign m1_rdata    = m1_rdata_q;
    assign m0_rdata_en = m0_rdata_en_q;
    assign m1_rdata_en = m1_rdata_en_q;
    assign err_orphan  = err_orphan_q;

endmodule

// File: tb/tb_ip_ram_arbiter.sv
// Testbench for ip_ram_arbiter: behavioural 16 KB RAM with a 4-clock read
// pipeline (and a stall control), per-master expected-data queues checked by a
// response monitor, and one task per scenario.
module tb_ip_ram_arbiter;

    logic        clk = 1'b0;
    logic        reset = 1'b1;

    logic [13:0] m0_address, m1_address;
    logic        m0_valid, m1_valid;
    logic        m0_ready, m1_ready;
    logic        m0_write, m1_write;
    logic [7:0]  m0_wdata, m1_wdata;
    logic [7:0]  m0_rdata, m1_rdata;
    logic        m0_rdata_en, m1_rdata_en;

    logic [13:0] bus_address;
    logic        bus_valid;
    logic        bus_write;
    logic [7:0]  bus_wdata;
    logic        bus_ready;
    logic [7:0]  bus_rdata;
    logic        bus_rdata_en;
    logic        err_orphan;

    // RAM model outputs and a bench-side injection port for stray strobes.
    logic        ram_en = 1'b0;
    logic [7:0]  ram_data = 8'h00;
    logic        inj_en = 1'b0;
    logic [7:0]  inj_data = 8'h00;
    logic        stall = 1'b0;

    assign bus_rdata_en = ram_en | inj_en;
    assign bus_rdata    = inj_en ? inj_data : ram_data;

    int checks = 0;
    int errors = 0;
    logic mon_en = 1'b0;

    logic [7:0] mem [0:16383];
    logic [7:0] q0 [$];
    logic [7:0] q1 [$];
    logic [7:0] exp0, exp1;

    typedef struct {
        logic [7:0] d;
        int         due;
    } rsp_t;
    rsp_t rq [$];
    rsp_t rsp;
    int   cyc = 0;

    ip_ram_arbiter dut (
        .clk          (clk),
        .reset        (reset),
        .m0_address   (m0_address),
        .m0_valid     (m0_valid),
        .m0_ready     (m0_ready),
        .m0_write     (m0_write),
        .m0_wdata     (m0_wdata),
        .m0_rdata     (m0_rdata),
        .m0_rdata_en  (m0_rdata_en),
        .m1_address   (m1_address),
        .m1_valid     (m1_valid),
        .m1_ready     (m1_ready),
        .m1_write     (m1_write),
        .m1_wdata     (m1_wdata),
        .m1_rdata     (m1_rdata),
        .m1_rdata_en  (m1_rdata_en),
        .bus_address  (bus_address),
        .bus_valid    (bus_valid),
        .bus_write    (bus_write),
        .bus_wdata    (bus_wdata),
        .bus_ready    (bus_ready),
        .bus_rdata    (bus_rdata),
        .bus_rdata_en (bus_rdata_en),
        .err_orphan   (err_orphan)
    );

    always #5 clk = ~clk;

    // RAM model: a read accepted at edge N raises bus_rdata_en between edges
    // N+3 and N+4, so the master strobe follows edge N+4. Not reset with DUT.
    always @(posedge clk) begin
        cyc = cyc + 1;
        if (ram_en && rq.size() > 0) void'(rq.pop_front());
        if (bus_valid === 1'b1 && bus_ready) begin
            if (bus_write) begin
                mem[bus_address] = bus_wdata;
            end else begin
                rsp.d   = mem[bus_address];
                rsp.due = cyc + 3;
                rq.push_back(rsp);
            end
        end
        if (!stall && rq.size() > 0 && rq[0].due <= cyc) begin
            ram_en   <= 1'b1;
            ram_data <= rq[0].d;
        end else begin
            ram_en   <= 1'b0;
            ram_data <= 8'h00;
        end
    end

    // Response monitor: every strobe must match the head of its master's queue.
    always @(negedge clk) begin
        if (mon_en) begin
            checks++;
            if (m0_rdata_en === 1'b1) begin
                if (q0.size() == 0) begin
                    errors++;
                    $display("FAIL m0_resp: unexpected strobe, data=%02h, nothing expected", m0_rdata);
                end else begin
                    exp0 = q0.pop_front();
                    if (m0_rdata !== exp0) begin
                        errors++;
                        $display("FAIL m0_resp: got %02h expected %02h", m0_rdata, exp0);
                    end
                end
            end else if (m0_rdata_en !== 1'b0 || m0_rdata !== 8'h00) begin
                errors++;
                $display("FAIL m0_idle: en=%b data=%02h expected en=0 data=00", m0_rdata_en, m0_rdata);
            end
            checks++;
            if (m1_rdata_en === 1'b1) begin
                if (q1.size() == 0) begin
                    errors++;
                    $display("FAIL m1_resp: unexpected strobe, data=%02h, nothing expected", m1_rdata);
                end else begin
                    exp1 = q1.pop_front();
                    if (m1_rdata !== exp1) begin
                        errors++;
                        $display("FAIL m1_resp: got %02h expected %02h", m1_rdata, exp1);
                    end
                end
            end else if (m1_rdata_en !== 1'b0 || m1_rdata !== 8'h00) begin
                errors++;
                $display("FAIL m1_idle: en=%b data=%02h expected en=0 data=00", m1_rdata_en, m1_rdata);
            end
        end
    end

    // Present one request for one cycle (other master idle) and check ready.
    task automatic drive_req(input bit m, input bit wr, input logic [13:0] a,
                             input logic [7:0] d, input bit exp_rdy,
                             input logic [7:0] exp_data, input string name);
        logic got;
        @(negedge clk);
        if (!m) begin
            m0_valid = 1'b1; m0_write = wr; m0_address = a; m0_wdata = d;
            m1_valid = 1'b0;
        end else begin
            m1_valid = 1'b1; m1_write = wr; m1_address = a; m1_wdata = d;
            m0_valid = 1'b0;
        end
        #1;
        got = m ? m1_ready : m0_ready;
        checks++;
        if (got !== exp_rdy) begin
            errors++;
            $display("FAIL %s: ready=%b expected %b", name, got, exp_rdy);
        end
        if (got === 1'b1 && !wr) begin
            if (!m) q0.push_back(exp_data);
            else    q1.push_back(exp_data);
        end
    endtask

    task automatic idle();
        @(negedge clk);
        m0_valid = 1'b0;
        m1_valid = 1'b0;
    endtask

    // Wait (bounded) until every expected response has been delivered.
    task automatic wait_idle(input string name);
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            #1;
            if (q0.size() == 0 && q1.size() == 0) break;
        end
        checks++;
        if (q0.size() != 0 || q1.size() != 0) begin
            errors++;
            $display("FAIL %s: responses missing, pending m0=%0d m1=%0d expected 0", name, q0.size(), q1.size());
        end
    endtask

    // Reset for n cycles; returns one negedge before the first RUN cycle.
    task automatic do_reset(input int n);
        @(negedge clk);
        reset = 1'b1;
        m0_valid = 1'b0;
        m1_valid = 1'b0;
        q0.delete();
        q1.delete();
        repeat (n) @(negedge clk);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        checks++;
        if (err_orphan !== 1'b0) begin
            errors++;
            $display("FAIL reset_orphan_clear: err_orphan=%b expected 0", err_orphan);
        end
    endtask

    task automatic test_reset();
        m0_valid = 1'b1; m0_write = 1'b0; m0_address = 14'h0040; m0_wdata = 8'h00;
        m1_valid = 1'b1; m1_write = 1'b1; m1_address = 14'h2040; m1_wdata = 8'hC3;
        reset = 1'b1;
        @(negedge clk);
        mon_en = 1'b1;
        #1;
        checks++;
        if (m0_ready !== 1'b0 || m1_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_ready: m0=%b m1=%b expected 0 0", m0_ready, m1_ready);
        end
        checks++;
        if (bus_valid !== 1'b0 || bus_write !== 1'b0 || bus_address !== 14'h0 || bus_wdata !== 8'h00) begin
            errors++;
            $display("FAIL reset_bus: valid=%b write=%b addr=%h wdata=%h expected all 0",
                     bus_valid, bus_write, bus_address, bus_wdata);
        end
        checks++;
        if (err_orphan !== 1'b0) begin
            errors++;
            $display("FAIL reset_orphan: err_orphan=%b expected 0", err_orphan);
        end
        repeat (2) @(negedge clk);
        reset = 1'b0;
        for (int c = 1; c <= 5; c++) begin
            inj_en   = (c == 2);
            inj_data = 8'h5A;
            #1;
            if (c <= 4) begin
                checks++;
                if (m0_ready !== 1'b0 || m1_ready !== 1'b0 || bus_valid !== 1'b0) begin
                    errors++;
                    $display("FAIL drain_cycle%0d: m0_ready=%b m1_ready=%b bus_valid=%b expected 0 0 0",
                             c, m0_ready, m1_ready, bus_valid);
                end
                @(negedge clk);
            end else begin
                checks++;
                if (m0_ready !== 1'b1 || m1_ready !== 1'b0) begin
                    errors++;
                    $display("FAIL first_run_grant: m0_ready=%b m1_ready=%b expected 1 0", m0_ready, m1_ready);
                end
                if (m0_ready === 1'b1) q0.push_back(mem[14'h0040]);
            end
        end
        idle();
        #1;
        checks++;
        if (err_orphan !== 1'b0) begin
            errors++;
            $display("FAIL drain_inject_orphan: err_orphan=%b expected 0", err_orphan);
        end
        wait_idle("reset_first_read");
    endtask

    task automatic test_single_read();
        logic exp_en;
        @(negedge clk);
        m0_valid = 1'b1; m0_write = 1'b0; m0_address = 14'h0123;
        m1_valid = 1'b0;
        #1;
        checks++;
        if (m0_ready !== 1'b1) begin
            errors++;
            $display("FAIL single_accept: m0_ready=%b expected 1", m0_ready);
        end
        if (m0_ready === 1'b1) q0.push_back(8'hA5);
        @(negedge clk);
        m0_valid = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            #1;
            exp_en = (k == 4);
            checks++;
            if (m0_rdata_en !== exp_en || m1_rdata_en !== 1'b0) begin
                errors++;
                $display("FAIL single_latency_k%0d: m0_en=%b m1_en=%b expected %b 0",
                         k, m0_rdata_en, m1_rdata_en, exp_en);
            end
        end
        wait_idle("single_read");
    endtask

    task automatic test_write();
        @(negedge clk);
        m0_valid = 1'b1; m0_write = 1'b1; m0_address = 14'h0300; m0_wdata = 8'h99;
        m1_valid = 1'b0;
        #1;
        checks++;
        if (m0_ready !== 1'b1 || bus_valid !== 1'b1 || bus_write !== 1'b1 ||
            bus_address !== 14'h0300 || bus_wdata !== 8'h99) begin
            errors++;
            $display("FAIL write_bus: ready=%b valid=%b write=%b addr=%h wdata=%h expected 1 1 1 0300 99",
                     m0_ready, bus_valid, bus_write, bus_address, bus_wdata);
        end
        drive_req(1'b0, 1'b0, 14'h0300, 8'h00, 1'b1, 8'h99, "m0_readback");
        drive_req(1'b1, 1'b1, 14'h3001, 8'h66, 1'b1, 8'h00, "m1_write");
        drive_req(1'b1, 1'b0, 14'h3001, 8'h00, 1'b1, 8'h66, "m1_readback");
        idle();
        wait_idle("write_readback");
    endtask

    task automatic test_alternate();
        logic [13:0] a0, a1;
        bit          adv0, adv1, gm, exp_m;
        int          grants;
        a0 = 14'h0010; a1 = 14'h2000;
        adv0 = 1'b0; adv1 = 1'b0; exp_m = 1'b0; grants = 0;
        m0_write = 1'b0; m1_write = 1'b0;
        for (int c = 0; c < 80 && grants < 12; c++) begin
            @(negedge clk);
            if (adv0) a0 = a0 + 14'd1;
            if (adv1) a1 = a1 + 14'd1;
            adv0 = 1'b0; adv1 = 1'b0;
            m0_valid = 1'b1; m0_address = a0;
            m1_valid = 1'b1; m1_address = a1;
            #1;
            checks++;
            if (m0_ready === 1'b1 && m1_ready === 1'b1) begin
                errors++;
                $display("FAIL alt_exclusive: both readies high");
            end else if (m0_ready === 1'b1 || m1_ready === 1'b1) begin
                gm = (m1_ready === 1'b1);
                checks++;
                if (gm !== exp_m) begin
                    errors++;
                    $display("FAIL alt_grant%0d: got m%0d expected m%0d", grants, gm, exp_m);
                end
                if (!gm) begin q0.push_back(mem[a0]); adv0 = 1'b1; end
                else     begin q1.push_back(mem[a1]); adv1 = 1'b1; end
                grants++;
`ifndef IP_RAM_ARB_FIXED_PRIORITY_EN
                exp_m = !exp_m;
`endif
            end
        end
        checks++;
        if (grants < 12) begin
            errors++;
            $display("FAIL alt_timeout: %0d grants expected 12", grants);
        end
        idle();
        wait_idle("alternate");
    endtask

    task automatic test_stall();
        stall = 1'b1;
        for (int i = 0; i < 4; i++)
            drive_req(1'b1, 1'b0, 14'h1000 + 14'(i), 8'h00, 1'b1, mem[14'h1000 + 14'(i)], "stall_read");
        for (int i = 0; i < 3; i++)
            drive_req(1'b1, 1'b0, 14'h1004, 8'h00, 1'b0, 8'h00, "stall_full_block");
        drive_req(1'b1, 1'b1, 14'h3002, 8'h11, 1'b1, 8'h00, "stall_write_while_full");
        drive_req(1'b1, 1'b0, 14'h1004, 8'h00, 1'b0, 8'h00, "stall_release_cycle");
        stall = 1'b0;
        drive_req(1'b1, 1'b0, 14'h1004, 8'h00, 1'b0, 8'h00, "stall_pop_cycle");
        drive_req(1'b1, 1'b0, 14'h1004, 8'h00, 1'b1, mem[14'h1004], "stall_after_pop");
        checks++;
        if (m1_rdata_en !== 1'b1) begin
            errors++;
            $display("FAIL stall_first_pop: m1_rdata_en=%b expected 1", m1_rdata_en);
        end
        idle();
        wait_idle("stall");
    endtask

    task automatic test_orphan();
        @(negedge clk);
        #1;
        checks++;
        if (err_orphan !== 1'b0) begin
            errors++;
            $display("FAIL orphan_before: err_orphan=%b expected 0", err_orphan);
        end
        @(negedge clk);
        inj_en = 1'b1; inj_data = 8'h3C;
        @(negedge clk);
        inj_en = 1'b0;
        #1;
        checks++;
        if (err_orphan !== 1'b1) begin
            errors++;
            $display("FAIL orphan_set: err_orphan=%b expected 1", err_orphan);
        end
        drive_req(1'b0, 1'b0, 14'h0123, 8'h00, 1'b1, 8'hA5, "orphan_then_read");
        idle();
        wait_idle("orphan_read");
        repeat (3) @(negedge clk);
        #1;
        checks++;
        if (err_orphan !== 1'b1) begin
            errors++;
            $display("FAIL orphan_sticky: err_orphan=%b expected 1", err_orphan);
        end
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 3; i++)
            drive_req(1'b0, 1'b0, 14'h0200 + 14'(i), 8'h00, 1'b1, 8'h00, "mid_read");
        @(negedge clk);
        m0_valid = 1'b0;
        reset = 1'b1;
        q0.delete();
        q1.delete();
        @(negedge clk);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        drive_req(1'b0, 1'b0, 14'h0201, 8'h00, 1'b1, mem[14'h0201], "post_drain_read");
        idle();
        wait_idle("post_drain_read");
        checks++;
        if (err_orphan !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset_orphan: err_orphan=%b expected 0", err_orphan);
        end
    endtask

    initial begin
        m0_valid = 1'b0; m0_write = 1'b0; m0_address = '0; m0_wdata = '0;
        m1_valid = 1'b0; m1_write = 1'b0; m1_address = '0; m1_wdata = '0;
        bus_ready = 1'b1;
        for (int a = 0; a < 16384; a++) mem[a] = 8'(a ^ (a >> 6) ^ 8'h5C);
        mem[14'h0123] = 8'hA5;

        test_reset();
        test_single_read();
        test_write();
        do_reset(2);
        test_alternate();
        test_stall();
        test_orphan();
        test_reset_mid();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

endmodule
